// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sort_pkg
// Purpose : Shared definitions for the 4-element sort engine and its output
//           serializer: element width, frame size, the frame type and the
//           serializer state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sort_pkg;

   localparam int DW     = 8;
   localparam int SORT_N = 4;

   // One sorted frame, element 0 in the least-significant slot.
   typedef logic [SORT_N-1:0][DW-1:0] frame_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

endpackage : sort_pkg
`default_nettype wire

// File: rtl/frame_fifo.sv
`default_nettype none
// ============================================================================
// Module  : frame_fifo
// Purpose : Small circular buffer of whole frames. Exposes the head entry and
//           the entry behind it so the reader can switch frames without a
//           bubble.
// Ports   : clk, rst_n (async, active-low)
//           i_push/i_data  : write a frame at the tail
//           i_pop          : retire the head frame
//           o_head/o_next  : head frame and the frame queued behind it
//           o_full/o_empty/o_count : occupancy
// Rev     : 1.0  initial release
// ============================================================================
module frame_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic [W-1:0]            i_data,
   input  logic                    i_pop,
   output logic [W-1:0]            o_head,
   output logic [W-1:0]            o_next,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_pop;
   logic          w_push;
   logic [AW-1:0] w_rd_next;

   assign w_pop     = i_pop & ~o_empty;
   // A push into a full buffer is legal only when the head leaves this cycle;
   // the write then lands in the slot being vacated.
   assign w_push    = i_push & (~o_full | w_pop);
   assign w_rd_next = r_rd_ptr + AW'(1);

   assign o_head  = r_mem[r_rd_ptr];
   assign o_next  = r_mem[w_rd_next];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   // Storage carries no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : frame_fifo
`default_nettype wire

// File: rtl/sort4_serializer.sv
`default_nettype none
// ============================================================================
// Module  : sort4_serializer
// Purpose : Buffers sorted 4-element frames and streams them out one element
//           per transfer with valid/ready handshaking. Flags dropped frames
//           (overflow) and frames that were not ascending (order_err).
// Ports   : clk, rst_n (async, active-low)
//           in_done, in_r0..in_r3 : frame input strobe and elements
//           clr                   : synchronous clear of sticky flags
//           out_data/out_valid/out_ready/out_idx/out_last : element stream
//           overflow, order_err   : sticky status flags
//           frames_pending        : frames held, including the one being sent
// Rev     : 1.0  initial release
// ============================================================================
module sort4_serializer #(
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_done,
   input  logic [DW-1:0]           in_r0,
   input  logic [DW-1:0]           in_r1,
   input  logic [DW-1:0]           in_r2,
   input  logic [DW-1:0]           in_r3,
   input  logic                    clr,
   output logic [DW-1:0]           out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_idx,
   output logic                    out_last,
   output logic                    overflow,
   output logic                    order_err,
   output logic [$clog2(DEPTH):0]  frames_pending
);

   localparam int FW = sort_pkg::SORT_N * DW;
   localparam int CW = $clog2(DEPTH) + 1;

   sort_pkg::state_e r_state;
   logic [DW-1:0]    r_data;
   logic [1:0]       r_idx;
   logic             r_overflow;
   logic             r_order_err;

   logic [FW-1:0]    w_in_frame;
   logic [FW-1:0]    w_head;
   logic [FW-1:0]    w_next;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic             w_xfer;
   logic             w_last_xfer;
   logic             w_accept;
   logic             w_push;
   logic             w_unsorted;
   logic [1:0]       w_idx_inc;

   function automatic logic [DW-1:0] f_elem(input logic [FW-1:0] frame,
                                            input logic [1:0]    idx);
      return frame[int'(idx)*DW +: DW];
   endfunction

   assign w_in_frame  = {in_r3, in_r2, in_r1, in_r0};
   assign w_xfer      = (r_state == sort_pkg::ST_EMIT) & out_ready;
   assign w_last_xfer = w_xfer & (r_idx == 2'd3);
   // A full buffer still takes a frame when the head retires this cycle.
   assign w_accept    = ~w_full | w_last_xfer;
   assign w_push      = in_done & w_accept;
   assign w_unsorted  = (in_r0 > in_r1) | (in_r1 > in_r2) | (in_r2 > in_r3);
   assign w_idx_inc   = r_idx + 2'd1;

   frame_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_frame_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_in_frame),
      .i_pop   (w_last_xfer),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= sort_pkg::ST_IDLE;
         r_idx   <= 2'd0;
         r_data  <= '0;
      end else begin
         case (r_state)
            sort_pkg::ST_IDLE: begin
               if (!w_empty) begin
                  r_state <= sort_pkg::ST_EMIT;
                  r_idx   <= 2'd0;
                  r_data  <= f_elem(w_head, 2'd0);
               end
            end
            sort_pkg::ST_EMIT: begin
               if (out_ready) begin
                  r_idx <= w_idx_inc;
                  if (r_idx != 2'd3) begin
                     r_data <= f_elem(w_head, w_idx_inc);
                  end else if (w_count > CW'(1)) begin
                     // Another frame already queued behind the head.
                     r_data <= f_elem(w_next, 2'd0);
                  end else if (w_push) begin
                     // Buffer drains to the frame arriving right now.
                     r_data <= in_r0;
                  end else begin
                     r_state <= sort_pkg::ST_IDLE;
                     r_data  <= '0;
                  end
               end
            end
            default: begin
               r_state <= sort_pkg::ST_IDLE;
            end
         endcase
      end
   end

   // Sticky flags: a set event in the clearing cycle takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_order_err <= 1'b0;
      end else begin
         r_overflow  <= (r_overflow  & ~clr) | (in_done & ~w_accept);
         r_order_err <= (r_order_err & ~clr) | (w_push & w_unsorted);
      end
   end

   assign out_valid      = (r_state == sort_pkg::ST_EMIT);
   assign out_data       = r_data;
   assign out_idx        = r_idx;
   assign out_last       = out_valid & (r_idx == 2'd3);
   assign overflow       = r_overflow;
   assign order_err      = r_order_err;
   assign frames_pending = w_count;

endmodule : sort4_serializer
`default_nettype wire

// File: tb/tb_sort4_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sort4_serializer
// Purpose : Self-checking bench for sort4_serializer. Directed scenarios plus
//           a randomized run against a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sort4_serializer;

   localparam int DW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_done = 1'b0;
   logic [DW-1:0] in_r0 = '0;
   logic [DW-1:0] in_r1 = '0;
   logic [DW-1:0] in_r2 = '0;
   logic [DW-1:0] in_r3 = '0;
   logic          clr = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [1:0]    out_idx;
   logic          out_last;
   logic          overflow;
   logic          order_err;
   logic [$clog2(DEPTH):0] frames_pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: frames waiting/being sent, element position, flags.
   logic [31:0] mq[$];
   int          m_idx;
   bit          m_valid;
   bit          m_ovf;
   bit          m_oerr;

   sort4_serializer #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_done        (in_done),
      .in_r0          (in_r0),
      .in_r1          (in_r1),
      .in_r2          (in_r2),
      .in_r3          (in_r3),
      .clr            (clr),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_idx        (out_idx),
      .out_last       (out_last),
      .overflow       (overflow),
      .order_err      (order_err),
      .frames_pending (frames_pending)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_idx   = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_oerr  = 1'b0;
   endtask

   function automatic logic [7:0] model_elem();
      logic [31:0] h;
      h = mq[0];
      return h[m_idx*8 +: 8];
   endfunction

   // Advance the model by one clock using the inputs currently driven, then
   // let the DUT take the same edge.
   task automatic tick();
      int cb;
      bit xfer, lst, acc, bad;
      if (rst_n) begin
         cb   = mq.size();
         xfer = m_valid && out_ready;
         lst  = xfer && (m_idx == 3);
         acc  = in_done && ((cb < DEPTH) || lst);
         bad  = (in_r0 > in_r1) || (in_r1 > in_r2) || (in_r2 > in_r3);
         if (clr) begin
            m_ovf  = 1'b0;
            m_oerr = 1'b0;
         end
         if (in_done && !acc) m_ovf = 1'b1;
         if (acc && bad) m_oerr = 1'b1;
         if (lst) void'(mq.pop_front());
         if (xfer) m_idx = (m_idx + 1) % 4;
         if (acc) mq.push_back({in_r3, in_r2, in_r1, in_r0});
         // Output is valid once a frame has been held across an edge.
         m_valid = (cb > 0) && (mq.size() > 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [31:0] f);
      in_r0   = f[7:0];
      in_r1   = f[15:8];
      in_r2   = f[23:16];
      in_r3   = f[31:24];
      in_done = 1'b1;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", out_data); end
      n_checks++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", out_last); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
      n_checks++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL reset_order_err: got %0b want 0", order_err); end
      n_checks++; if (frames_pending !== 2'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", frames_pending); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      logic [31:0] f;
      f = {8'd200, 8'd7, 8'd7, 8'd3};
      out_ready = 1'b1;
      drive_frame(f);
      tick();
      in_done = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: valid got %0b want 0", out_valid); end
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== f[k*8 +: 8] || out_idx !== 2'(k))
            begin n_fail++; $display("FAIL single_elem%0d: valid=%0b data=%0d idx=%0d want 1/%0d/%0d", k, out_valid, out_data, out_idx, f[k*8 +: 8], k); end
         n_checks++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL single_last%0d: got %0b want %0b", k, out_last, (k == 3)); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0 || frames_pending !== 2'd0 || overflow !== 1'b0 || order_err !== 1'b0)
         begin n_fail++; $display("FAIL single_end: valid=%0b pend=%0d ovf=%0b oerr=%0b want 0/0/0/0", out_valid, frames_pending, overflow, order_err); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive_frame({8'd4, 8'd3, 8'd2, 8'd1});
      tick();
      in_done = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd1 || out_idx !== 2'd0)
            begin n_fail++; $display("FAIL bp_hold%0d: valid=%0b data=%0d idx=%0d want 1/1/0", c, out_valid, out_data, out_idx); end
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== 8'(k + 1) || out_idx !== 2'(k))
            begin n_fail++; $display("FAIL bp_elem%0d: valid=%0b data=%0d idx=%0d want 1/%0d/%0d", k, out_valid, out_data, out_idx, k + 1, k); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end: valid got %0b want 0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [31:0] fa, fb, fc, both [2];
      fa = $urandom; fb = $urandom; fc = $urandom;
      both[0] = fa; both[1] = fb;
      pulse_clr();
      out_ready = 1'b0;
      drive_frame(fa); tick();
      drive_frame(fb); tick();
      drive_frame(fc); tick();
      in_done = 1'b0;
      n_checks++; if (frames_pending !== 2'd2) begin n_fail++; $display("FAIL ovf_pending: got %0d want 2", frames_pending); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         logic [31:0] f;
         f = both[k/4];
         n_checks++; if (out_valid !== 1'b1 || out_data !== f[(k%4)*8 +: 8])
            begin n_fail++; $display("FAIL ovf_stream%0d: valid=%0b data=%0d want 1/%0d", k, out_valid, out_data, f[(k%4)*8 +: 8]); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0 || frames_pending !== 2'd0)
         begin n_fail++; $display("FAIL ovf_drained: valid=%0b pend=%0d want 0/0", out_valid, frames_pending); end
      pulse_clr();
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] fa, fb, fc, seq [2];
      fa = $urandom; fb = $urandom; fc = $urandom;
      seq[0] = fb; seq[1] = fc;
      out_ready = 1'b0;
      drive_frame(fa); tick();
      drive_frame(fb); tick();
      in_done = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (3) tick();
      n_checks++; if (out_idx !== 2'd3 || frames_pending !== 2'd2)
         begin n_fail++; $display("FAIL fpp_setup: idx=%0d pend=%0d want 3/2", out_idx, frames_pending); end
      drive_frame(fc);
      tick();
      in_done = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0b want 0", overflow); end
      n_checks++; if (frames_pending !== 2'd2) begin n_fail++; $display("FAIL fpp_pending: got %0d want 2", frames_pending); end
      for (int k = 0; k < 8; k++) begin
         logic [31:0] f;
         f = seq[k/4];
         n_checks++; if (out_valid !== 1'b1 || out_data !== f[(k%4)*8 +: 8] || out_idx !== 2'(k%4))
            begin n_fail++; $display("FAIL fpp_stream%0d: valid=%0b data=%0d idx=%0d want 1/%0d/%0d", k, out_valid, out_data, out_idx, f[(k%4)*8 +: 8], k%4); end
         tick();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_end: valid got %0b want 0", out_valid); end
   endtask

   task automatic test_order_err();
      logic [31:0] f;
      f = {8'd6, 8'd5, 8'd4, 8'd9};
      pulse_clr();
      out_ready = 1'b1;
      drive_frame(f);
      tick();
      in_done = 1'b0;
      n_checks++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL oerr_set: got %0b want 1", order_err); end
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== f[k*8 +: 8])
            begin n_fail++; $display("FAIL oerr_elem%0d: valid=%0b data=%0d want 1/%0d", k, out_valid, out_data, f[k*8 +: 8]); end
         tick();
      end
      pulse_clr();
      n_checks++; if (order_err !== 1'b0) begin n_fail++; $display("FAIL oerr_clr: got %0b want 0", order_err); end
      // Clear and a new error in the same cycle: the error wins.
      clr = 1'b1;
      drive_frame({8'd3, 8'd2, 8'd1, 8'd5});
      tick();
      clr = 1'b0;
      in_done = 1'b0;
      n_checks++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL oerr_set_wins: got %0b want 1", order_err); end
      repeat (6) tick();
      pulse_clr();
   endtask

   task automatic test_reset_mid_frame();
      out_ready = 1'b1;
      drive_frame({8'd40, 8'd30, 8'd20, 8'd10});
      tick();
      in_done = 1'b0;
      tick();
      tick();
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd30)
         begin n_fail++; $display("FAIL rmf_pre: valid=%0b data=%0d want 1/30", out_valid, out_data); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (out_valid !== 1'b0 || frames_pending !== 2'd0 || out_data !== 8'd0)
         begin n_fail++; $display("FAIL rmf_async: valid=%0b pend=%0d data=%0d want 0/0/0", out_valid, frames_pending, out_data); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++; if (out_valid !== 1'b0 || frames_pending !== 2'd0)
            begin n_fail++; $display("FAIL rmf_after%0d: valid=%0b pend=%0d want 0/0", c, out_valid, frames_pending); end
      end
   endtask

   task automatic test_random();
      int v [4];
      int t;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_done   = ($urandom_range(0, 2) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr       = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < 4; i++) v[i] = $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3 - i; j++)
                  if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
         end
         in_r0 = 8'(v[0]); in_r1 = 8'(v[1]); in_r2 = 8'(v[2]); in_r3 = 8'(v[3]);
         tick();
         n_checks++; if (out_valid !== m_valid || out_idx !== 2'(m_idx) || out_last !== (m_valid && m_idx == 3))
            begin n_fail++; $display("FAIL rnd_ctrl@%0d: valid=%0b idx=%0d last=%0b want %0b/%0d/%0b", cyc, out_valid, out_idx, out_last, m_valid, m_idx, (m_valid && m_idx == 3)); end
         if (m_valid) begin
            n_checks++; if (out_data !== model_elem())
               begin n_fail++; $display("FAIL rnd_data@%0d: got %0d want %0d", cyc, out_data, model_elem()); end
         end
         n_checks++; if (frames_pending !== 2'(mq.size()) || overflow !== m_ovf || order_err !== m_oerr)
            begin n_fail++; $display("FAIL rnd_status@%0d: pend=%0d ovf=%0b oerr=%0b want %0d/%0b/%0b", cyc, frames_pending, overflow, order_err, mq.size(), m_ovf, m_oerr); end
      end
      in_done = 1'b0;
      clr     = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_frame();
      test_backpressure();
      test_overflow();
      test_full_push_pop();
      test_order_err();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sort4_serializer
`default_nettype wire

// File: doc/sort4_serializer.md
SORT4_SERIALIZER -- requirements
Module: sort4_serializer

Interface
REQ-001 The block SHALL expose these parameters:
- DW, 8, element width in bits.
- DEPTH, 2, frame buffer depth in frames (power of two, >=2).

REQ-002 The block SHALL expose these ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_done  in  1  one-cycle strobe; in_r0..in_r3 hold a sorted frame this cycle.
- in_r0, in_r1, in_r2, in_r3  in  DW each  frame elements, ascending order expected.
- clr  in  1  synchronous clear of sticky flags.
- out_data  out  DW  current element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_idx  out  2  element index within frame (0..3).
- out_last  out  1  high with element 3.
- overflow  out  1  sticky; a frame was dropped.
- order_err  out  1  sticky; an accepted frame was not ascending.
- frames_pending  out  $clog2(DEPTH)+1  frames buffered, including the one in transmission.

Function
REQ-003 On in_done=1, the block SHALL capture {in_r0..in_r3} into the frame FIFO tail, provided it is accepted per REQ-004.
REQ-004 A frame SHALL be accepted when frames_pending<DEPTH, or when frames_pending==DEPTH and the element-3 transfer (out_valid & out_ready & out_last) happens in the same cycle.
REQ-005 A frame not accepted SHALL be dropped, FIFO contents SHALL stay unchanged, and overflow SHALL be set to 1 on the next edge.
REQ-006 For each accepted frame, order_err SHALL be set if in_r0>in_r1, in_r1>in_r2, or in_r2>in_r3 (unsigned compare); the frame SHALL still be stored and emitted unchanged.
REQ-007 clr=1 SHALL zero overflow and order_err. A flag-setting event in the same cycle SHALL win (flag ends at 1).
REQ-008 Output FSM states:
- IDLE: out_valid=0.
- EMIT: out_valid=1, out_data = head frame element out_idx.
- Transitions: IDLE->EMIT when the FIFO is non-empty. EMIT->IDLE after the element-3 transfer if the FIFO is then empty. Otherwise EMIT stays, with out_idx=0 on the next frame.
REQ-009 Latency SHALL be one cycle: in_done at edge N into an empty block gives out_valid=1, out_idx=0, out_data=in_r0 after edge N+1.
REQ-010 A transfer SHALL occur when out_valid & out_ready. out_idx SHALL then increment, wrapping 3->0, and element 3 SHALL pop the head frame.
REQ-011 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-012 With out_ready held at 1, frames SHALL stream back-to-back, one element per cycle, with no bubble between frames.
REQ-013 out_last SHALL equal out_valid & (out_idx==3).
REQ-014 frames_pending SHALL be +1 on accepted push only, -1 on pop only, and unchanged on push and pop in the same cycle.
REQ-015 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-016 rst_n low SHALL immediately force:
- out_valid=0, out_data=0, out_idx=0, out_last=0;
- overflow=0, order_err=0, frames_pending=0;
- FSM=IDLE, FIFO pointers=0.
REQ-017 Reset mid-frame SHALL discard all buffered and partially sent frames; no element SHALL be emitted after rst_n rises until a new in_done.

Structure
REQ-018 Package sort_pkg SHALL hold DW, SORT_N=4, the frame typedef (SORT_N x DW array) and the FSM state enum, shared with the sort engine.
REQ-019 Buffering SHALL use one sub-module, frame_fifo (synchronous push/pop, full/empty/count, async active-low reset). Serializer FSM, order check and flags SHALL stay in sort4_serializer.

Verification
REQ-020 Single frame: in_done with 3,7,7,200 and out_ready=1 -> outputs 3,7,7,200 on four consecutive cycles, out_last only on 200, flags 0.
REQ-021 Backpressure: frame 1,2,3,4 with out_ready low for 5 cycles after valid -> out_data=1, out_idx=0 held for 5 cycles, then 1,2,3,4 in order.
REQ-022 Overflow: three in_done on consecutive cycles (frames A,B,C) with out_ready=0 -> frames_pending=2, overflow=1, only A then B emitted after out_ready rises.
REQ-023 Full push+pop: FIFO full and element 3 of head transferred in the same cycle as in_done -> frame accepted, overflow stays 0, frames_pending stays 2.
REQ-024 Order error: frame 9,4,5,6 -> order_err=1, emitted as 9,4,5,6. clr with no new error -> order_err=0.
REQ-025 Reset mid-frame: assert rst_n low after element 1 of 10,20,30,40 -> out_valid=0 at once, nothing emitted after release, frames_pending=0.
